fifo_uart_tx: RTL and testbench
===============================

# fifo_uart_tx

Serial transmitter that drains the transmit FIFO and sends each word as an asynchronous UART-style frame. It has a start bit, LSB-first data, optional even parity and one stop bit. It sits directly downstream of the FIFO. It pops one word at a time through the FIFO's `rd_en`/`empty` pair and consumes the FIFO's registered `rdata`, which is valid one cycle after the pop. It drives the line `tx` toward the link.

## Interface
Parameters:
- `DATA_WIDTH`, 4: FIFO word width; number of data bits per frame.
- `CLKS_PER_BIT`, 16: clk cycles per serial bit; must be ≥ 2.
- `PARITY_EN`, 1: 1 inserts an even-parity bit after the data; 0 omits it.

Ports:
- `clk`, input, 1: clock.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `enable`, input, 1: permits starting new frames. It never aborts a frame in progress.
- `fifo_empty`, input, 1: FIFO empty flag.
- `fifo_rd_en`, output, 1: FIFO pop request. Registered; a single-cycle pulse.
- `fifo_rdata`, input, DATA_WIDTH: FIFO read data. Valid in the cycle after the `fifo_rd_en` pulse.
- `tx`, output, 1: serial line. Idles high. Registered.
- `busy`, output, 1: high in every state except IDLE.
- `frame_done`, output, 1: one-cycle pulse at the end of the stop bit.

## Operation
- Reset values: state IDLE, `tx`=1, `fifo_rd_en`=0, `busy`=0, `frame_done`=0, and all counters and the shift register are 0.
- **IDLE**
  - If `enable` && !`fifo_empty` at a clock edge, go to FETCH and assert `fifo_rd_en` for that one cycle.
  - Otherwise stay in IDLE.
- **FETCH**
  - `fifo_rd_en`=1 for exactly one cycle, then go to LOAD.
- **LOAD**
  - Capture `fifo_rdata` into the shift register.
  - Compute `par` = XOR of all data bits, which gives even parity.
  - Clear the baud counter and go to START.
- **START**
  - `tx`=0 for CLKS_PER_BIT cycles, then go to DATA with the bit index at 0.
- **DATA**
  - `tx` = shift register bit[0], held for CLKS_PER_BIT cycles.
  - After each bit, shift right and increment the bit index.
  - After DATA_WIDTH bits, go to PARITY if PARITY_EN, else to STOP.
- **PARITY**
  - `tx`=`par` for CLKS_PER_BIT cycles, then go to STOP.
- **STOP**
  - `tx`=1 for CLKS_PER_BIT cycles.
  - On the final cycle's edge, pulse `frame_done` and return to IDLE.
- Counter widths:
  - The baud counter is $clog2(CLKS_PER_BIT) bits and counts 0..CLKS_PER_BIT-1.
  - The bit index is $clog2(DATA_WIDTH+1) bits.
  - Neither counter ever wraps mid-bit.
- Exactly one FIFO pop occurs per frame. `fifo_rd_en` is never asserted while `fifo_empty`=1 was sampled, and never in any state other than FETCH.
- `enable` deasserted mid-frame: the current frame completes normally, and no new fetch happens until `enable` returns to 1.
- Asynchronous reset mid-frame:
  - `tx` goes high immediately, the state returns to IDLE and `fifo_rd_en` drops.
  - The already-popped word is discarded; it is not re-read.
- The `fifo_rdata` value is latched only in LOAD. Changes to it at any other time have no effect.

## Timing
- Let edge k be the edge at which IDLE samples `enable`=1 and `fifo_empty`=0.
  - `fifo_rd_en` is high between edge k and edge k+1.
  - Data is captured at edge k+2.
  - `tx` falls after edge k+2.
- Frame length is (2 + DATA_WIDTH + PARITY_EN) × CLKS_PER_BIT cycles, measured from the `tx` fall to the STOP exit.
- `frame_done` is high for exactly the one cycle after the STOP exit edge. `busy` falls at that same edge.
- Back-to-back frames (FIFO non-empty, `enable`=1): the line stays idle high for exactly 3 cycles between the end of one stop bit and the next start bit (IDLE, FETCH, LOAD).
- Throughput is one word per (2 + DATA_WIDTH + PARITY_EN) × CLKS_PER_BIT + 3 cycles.

## Test plan
All scenarios use DATA_WIDTH=4, CLKS_PER_BIT=4, PARITY_EN=1.

- **Reset:** hold `rst_n`=0 with `fifo_empty`=0 → `tx`=1, `fifo_rd_en`=0, `busy`=0, `frame_done`=0. After release, the first `fifo_rd_en` pulse comes 1 edge after `enable`=1 is sampled.
- **Single word:** load 4'hA, then `enable`=1 → exactly one `fifo_rd_en` pulse. `tx` carries 0,0,1,0,1,0,1 (start, data 0/1/0/1 LSB first, parity 0, stop), each bit 4 cycles, 28 cycles total. `frame_done` pulses once, then `busy`=0.
- **Parity:** send 4'h7 → the data bits are 1,1,1,0 and the parity bit is 1. Send 4'h0 → the parity bit is 0.
- **Back-to-back:** load 4'h3, 4'hC, 4'h5 → three frames in order with exactly 3 high idle cycles between consecutive stop and start bits. `fifo_rd_en` pulses exactly 3 times, and there is no pop once the FIFO is empty.
- **Enable gating:** drop `enable` during the DATA bits of a frame with 2 words queued → the current frame completes, and there is no further pop or start bit while `enable`=0. Re-enabling starts the next frame 3 edges later.
- **Mid-frame reset:** assert `rst_n`=0 during the PARITY bit → `tx`=1 immediately and the state is IDLE. After release with 1 word still queued, the next frame transmits that word, not the discarded one.

Source files
------------

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops one FIFO word per frame and serialises it as start, LSB-first data, optional even parity, stop.
module fifo_uart_tx #(
    parameter int DATA_WIDTH   = 4,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    output logic                  tx,
    output logic                  busy,
    output logic                  frame_done
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, DATA, PARITY, STOP} state_e;

    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [BW-1:0]         idx_q, idx_d;
    logic [DATA_WIDTH-1:0] sh_q, sh_d;
    logic                  par_q, par_d;
    logic                  tx_q, tx_d;
    logic                  rd_en_q, rd_en_d;
    logic                  done_q, done_d;
    logic                  serial, bit_end, last_bit;

    assign serial     = state_q inside {START, DATA, PARITY, STOP};
    assign bit_end    = serial && (cnt_q == CW'(CLKS_PER_BIT - 1));
    assign last_bit   = idx_q == BW'(DATA_WIDTH - 1);
    assign tx         = tx_q;
    assign fifo_rd_en = rd_en_q;
    assign frame_done = done_q;
    assign busy       = state_q != IDLE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            rd_en_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            rd_en_q <= rd_en_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = (enable && !fifo_empty) ? FETCH : IDLE;
            FETCH:   state_d = LOAD;
            LOAD:    state_d = START;
            START:   state_d = bit_end ? DATA : START;
            DATA:    state_d = !(bit_end && last_bit) ? DATA : (PARITY_EN != 0) ? PARITY : STOP;
            PARITY:  state_d = bit_end ? STOP : PARITY;
            STOP:    state_d = bit_end ? IDLE : STOP;
            default: state_d = IDLE;
        endcase
    end

    // Baud counter runs only while a bit is on the line; LOAD leaves it cleared for START.
    always_comb begin
        cnt_d = (serial && !bit_end) ? cnt_q + CW'(1) : '0;
        idx_d = (state_q == START) ? '0 : (state_q == DATA && bit_end) ? idx_q + BW'(1) : idx_q;
        sh_d  = (state_q == LOAD) ? fifo_rdata : (state_q == DATA && bit_end) ? sh_q >> 1 : sh_q;
        par_d = (state_q == LOAD) ? ^fifo_rdata : par_q;
    end

    // tx is registered from the next state so each bit appears right after its entering edge.
    always_comb begin
        rd_en_d = state_d == FETCH;
        done_d  = state_q == STOP && bit_end;
        tx_d    = (state_d == START) ? 1'b0 : (state_d == DATA) ? sh_d[0] : (state_d == PARITY) ? par_q : 1'b1;
    end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: FIFO model plus line decoder; tasks compare decoded frames against a queue of pushed words.
module tb_fifo_uart_tx;
    localparam int W  = 4;
    localparam int C  = 4;
    localparam int P  = 1;
    localparam int NB = 2 + W + P;
    localparam int FL = NB * C;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         enable = 1'b0;
    logic         fifo_empty, fifo_rd_en, tx, busy, frame_done;
    logic [W-1:0] fifo_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fifo_uart_tx #(.DATA_WIDTH(W), .CLKS_PER_BIT(C), .PARITY_EN(P)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_rd_en(fifo_rd_en), .fifo_rdata(fifo_rdata), .tx(tx), .busy(busy),
        .frame_done(frame_done)
    );

    // FIFO with registered read data; rdata is scrambled whenever no pop happens
    logic [W-1:0] mem [0:63];
    int   wr_ptr = 0;
    int   rd_ptr = 0;
    int   bad_pops = 0;
    logic rd_en_prev = 1'b0;
    logic [W-1:0] exp_q[$];

    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        rd_en_prev <= fifo_rd_en;
        if (fifo_rd_en && (fifo_empty || rd_en_prev)) bad_pops <= bad_pops + 1;
        if (fifo_rd_en && !fifo_empty) begin
            fifo_rdata <= mem[rd_ptr[5:0]];
            rd_ptr     <= rd_ptr + 1;
        end else begin
            fifo_rdata <= W'($urandom);
        end
    end

    task automatic push_word(input logic [W-1:0] w);
        mem[wr_ptr[5:0]] = w;
        wr_ptr = wr_ptr + 1;
        exp_q.push_back(w);
    endtask

    // Line decoder: samples every cycle from a start bit for one full frame
    typedef struct {
        logic [W-1:0] data;
        logic         par;
        logic         ok;
        int           gap;
    } frame_t;

    frame_t        rx_q[$];
    int            mon_pos = -1;
    int            gap_cnt = 0;
    int            cur_gap = 0;
    logic [FL-1:0] samp = '0;

    function automatic frame_t decode(input logic [FL-1:0] s, input int gap);
        frame_t      f;
        logic [NB-1:0] b;
        f.ok = 1'b1;
        for (int i = 0; i < NB; i++) begin
            b[i] = s[i*C];
            for (int j = 1; j < C; j++) if (s[i*C+j] !== s[i*C]) f.ok = 1'b0;
        end
        if (b[0] !== 1'b0 || b[NB-1] !== 1'b1) f.ok = 1'b0;
        f.data = b[W:1];
        f.par  = b[W+1];
        f.gap  = gap;
        return f;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            mon_pos <= -1;
            gap_cnt <= 0;
        end else if (mon_pos < 0) begin
            if (tx === 1'b0) begin
                samp[0] <= 1'b0;
                mon_pos <= 1;
                cur_gap <= gap_cnt;
            end else begin
                gap_cnt <= gap_cnt + 1;
            end
        end else if (mon_pos == FL - 1) begin
            rx_q.push_back(decode({tx, samp[FL-2:0]}, cur_gap));
            mon_pos <= -1;
            gap_cnt <= 0;
        end else begin
            samp[mon_pos] <= tx;
            mon_pos <= mon_pos + 1;
        end
    end

    task automatic wait_done(input int n, output bit ok);
        int seen = 0;
        for (int i = 0; i < 200 * n && seen < n; i++) begin
            @(negedge clk);
            if (frame_done === 1'b1) seen++;
        end
        ok = (seen == n);
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (tx === 1'b0) ok = 1'b1;
        end
    endtask

    task automatic test_reset;
        bit ok;
        frame_t f;
        logic [W-1:0] e;
        enable = 1'b1;
        push_word(4'h9);
        repeat (3) @(negedge clk);
        n_cmp++; if (tx !== 1'b1) begin n_bad++; $display("FAIL reset_tx: got %b need 1", tx); end
        n_cmp++; if (fifo_rd_en !== 1'b0) begin n_bad++; $display("FAIL reset_rd_en: got %b need 0", fifo_rd_en); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b need 0", busy); end
        n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b need 0", frame_done); end
        enable = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (fifo_rd_en !== 1'b0 || rd_ptr != 0) begin n_bad++; $display("FAIL reset_no_pop: rd_en=%b pops=%0d need 0/0", fifo_rd_en, rd_ptr); end
        enable = 1'b1;
        @(negedge clk);
        n_cmp++; if (fifo_rd_en !== 1'b1) begin n_bad++; $display("FAIL reset_first_pop: got %b need 1", fifo_rd_en); end
        wait_done(1, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL reset_frame_timeout: got no frame_done need 1"); end
        @(negedge clk);
        if (rx_q.size() == 0 || exp_q.size() == 0) begin
            n_cmp++; n_bad++; $display("FAIL reset_frame: got %0d frames need 1", rx_q.size());
        end else begin
            f = rx_q.pop_front(); e = exp_q.pop_front();
            n_cmp++; if (f.data !== e || f.par !== ^e || !f.ok) begin n_bad++; $display("FAIL reset_frame: got %h/%b/%b need %h/%b/1", f.data, f.par, f.ok, e, ^e); end
        end
    endtask

    task automatic test_single;
        bit ok;
        frame_t f;
        logic [W-1:0] e;
        int p0 = rd_ptr;
        int d0 = 0;
        enable = 1'b0;
        @(negedge clk);
        push_word(4'hA);
        enable = 1'b1;
        wait_done(1, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL single_timeout: got no frame_done need 1"); end
        n_cmp++; if (busy !== 1'b0 || tx !== 1'b1) begin n_bad++; $display("FAIL single_end: busy=%b tx=%b need 0/1", busy, tx); end
        @(negedge clk);
        n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL single_done_width: got %b need 0", frame_done); end
        repeat (5) begin @(negedge clk); if (frame_done === 1'b1) d0++; end
        n_cmp++; if (rd_ptr - p0 != 1 || d0 != 0) begin n_bad++; $display("FAIL single_pops: pops=%0d extra_done=%0d need 1/0", rd_ptr - p0, d0); end
        if (rx_q.size() == 0 || exp_q.size() == 0) begin
            n_cmp++; n_bad++; $display("FAIL single_frame: got %0d frames need 1", rx_q.size());
        end else begin
            f = rx_q.pop_front(); e = exp_q.pop_front();
            n_cmp++; if (f.data !== e || f.par !== 1'b0 || !f.ok) begin n_bad++; $display("FAIL single_frame: got %h/%b/%b need %h/0/1", f.data, f.par, f.ok, e); end
        end
    endtask

    task automatic test_parity;
        bit ok;
        frame_t f;
        logic [W-1:0] e;
        logic [1:0] need_par = 2'b01;
        push_word(4'h7);
        push_word(4'h0);
        wait_done(2, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL parity_timeout: got <2 frame_done need 2"); end
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            if (rx_q.size() == 0 || exp_q.size() == 0) begin
                n_cmp++; n_bad++; $display("FAIL parity_frame%0d: missing frame", i);
            end else begin
                f = rx_q.pop_front(); e = exp_q.pop_front();
                n_cmp++; if (f.data !== e || f.par !== need_par[i] || !f.ok) begin n_bad++; $display("FAIL parity_frame%0d: got %h/%b/%b need %h/%b/1", i, f.data, f.par, f.ok, e, need_par[i]); end
            end
        end
    endtask

    task automatic test_back_to_back;
        bit ok;
        frame_t f;
        logic [W-1:0] e;
        int p0;
        enable = 1'b0;
        @(negedge clk);
        p0 = rd_ptr;
        push_word(4'h3);
        push_word(4'hC);
        push_word(4'h5);
        enable = 1'b1;
        wait_done(3, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL b2b_timeout: got <3 frame_done need 3"); end
        repeat (20) @(negedge clk);
        n_cmp++; if (rd_ptr - p0 != 3 || busy !== 1'b0) begin n_bad++; $display("FAIL b2b_pops: pops=%0d busy=%b need 3/0", rd_ptr - p0, busy); end
        for (int i = 0; i < 3; i++) begin
            if (rx_q.size() == 0 || exp_q.size() == 0) begin
                n_cmp++; n_bad++; $display("FAIL b2b_frame%0d: missing frame", i);
            end else begin
                f = rx_q.pop_front(); e = exp_q.pop_front();
                n_cmp++; if (f.data !== e || f.par !== ^e || !f.ok) begin n_bad++; $display("FAIL b2b_frame%0d: got %h/%b/%b need %h/%b/1", i, f.data, f.par, f.ok, e, ^e); end
                if (i > 0) begin
                    n_cmp++; if (f.gap != 3) begin n_bad++; $display("FAIL b2b_gap%0d: got %0d need 3", i, f.gap); end
                end
            end
        end
    endtask

    task automatic test_enable_gating;
        bit ok;
        frame_t f;
        logic [W-1:0] e;
        int p0;
        enable = 1'b0;
        @(negedge clk);
        p0 = rd_ptr;
        push_word(4'h6);
        push_word(4'h9);
        enable = 1'b1;
        wait_start(ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL gate_start: got no start bit need one"); end
        repeat (6) @(negedge clk);
        enable = 1'b0;
        wait_done(1, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL gate_timeout: got no frame_done need 1"); end
        repeat (40) @(negedge clk);
        n_cmp++; if (rd_ptr - p0 != 1 || rx_q.size() != 1 || busy !== 1'b0 || tx !== 1'b1) begin
            n_bad++; $display("FAIL gate_hold: pops=%0d frames=%0d busy=%b tx=%b need 1/1/0/1", rd_ptr - p0, rx_q.size(), busy, tx);
        end
        if (rx_q.size() != 0 && exp_q.size() != 0) begin
            f = rx_q.pop_front(); e = exp_q.pop_front();
            n_cmp++; if (f.data !== e || f.par !== ^e || !f.ok) begin n_bad++; $display("FAIL gate_frame0: got %h/%b/%b need %h/%b/1", f.data, f.par, f.ok, e, ^e); end
        end
        enable = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (tx !== 1'b1) begin n_bad++; $display("FAIL gate_early_start: got tx=%b need 1", tx); end
        @(negedge clk);
        n_cmp++; if (tx !== 1'b0) begin n_bad++; $display("FAIL gate_restart: got tx=%b need 0", tx); end
        wait_done(1, ok);
        @(negedge clk);
        if (!ok || rx_q.size() == 0 || exp_q.size() == 0) begin
            n_cmp++; n_bad++; $display("FAIL gate_frame1: got %0d frames need 1", rx_q.size());
        end else begin
            f = rx_q.pop_front(); e = exp_q.pop_front();
            n_cmp++; if (f.data !== e || f.par !== ^e || !f.ok) begin n_bad++; $display("FAIL gate_frame1: got %h/%b/%b need %h/%b/1", f.data, f.par, f.ok, e, ^e); end
        end
    endtask

    task automatic test_mid_reset;
        bit ok;
        frame_t f;
        logic [W-1:0] e;
        int p0;
        enable = 1'b0;
        @(negedge clk);
        p0 = rd_ptr;
        push_word(4'h5);
        push_word(4'hE);
        enable = 1'b1;
        wait_start(ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL rst_start: got no start bit need one"); end
        repeat (4 * C + C + 1) @(negedge clk);
        n_cmp++; if (tx !== 1'b0) begin n_bad++; $display("FAIL rst_parity_bit: got %b need 0", tx); end
        #1 rst_n = 1'b0;
        #1;
        n_cmp++; if (tx !== 1'b1 || busy !== 1'b0 || fifo_rd_en !== 1'b0) begin
            n_bad++; $display("FAIL rst_async: tx=%b busy=%b rd_en=%b need 1/0/0", tx, busy, fifo_rd_en);
        end
        void'(exp_q.pop_front());
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_done(1, ok);
        @(negedge clk);
        n_cmp++; if (rd_ptr - p0 != 2 || rx_q.size() != 1) begin n_bad++; $display("FAIL rst_pops: pops=%0d frames=%0d need 2/1", rd_ptr - p0, rx_q.size()); end
        if (!ok || rx_q.size() == 0 || exp_q.size() == 0) begin
            n_cmp++; n_bad++; $display("FAIL rst_frame: got no frame need one");
        end else begin
            f = rx_q.pop_front(); e = exp_q.pop_front();
            n_cmp++; if (f.data !== e || f.par !== ^e || !f.ok) begin n_bad++; $display("FAIL rst_frame: got %h/%b/%b need %h/%b/1", f.data, f.par, f.ok, e, ^e); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_parity();
        test_back_to_back();
        test_enable_gating();
        test_mid_reset();
        n_cmp++; if (bad_pops != 0) begin n_bad++; $display("FAIL pop_protocol: got %0d bad pops need 0", bad_pops); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
